// File: rtl/dmem_lsu.sv
// Load/store unit at the EX/MEM boundary: turns a pipeline memory request into one
// valid/ready bus transaction, formats sub-word stores, and extends sub-word loads.
module dmem_lsu #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_mem_read,
    input  logic                  i_mem_write,
    input  logic [2:0]            i_funct3,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic                  o_stall,
    output logic                  o_done,
    output logic [DATA_WIDTH-1:0] o_rdata,
    output logic                  o_misaligned,
    output logic                  o_bus_err,
    output logic                  o_bus_valid,
    input  logic                  i_bus_ready,
    output logic                  o_bus_we,
    output logic [ADDR_WIDTH-1:0] o_bus_addr,
    output logic [3:0]            o_bus_be,
    output logic [DATA_WIDTH-1:0] o_bus_wdata,
    input  logic                  i_bus_rvalid,
    input  logic [DATA_WIDTH-1:0] i_bus_rdata,
    input  logic                  i_bus_err
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  bus_valid_q, bus_valid_d;
    logic                  bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]            bus_be_q, bus_be_d;
    logic [DATA_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]            funct3_q, funct3_d;
    logic [1:0]            lane_q, lane_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    logic                  req;
    logic                  bad_req;
    logic [3:0]            be_fmt;
    logic [DATA_WIDTH-1:0] wdata_fmt;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  stall;
    logic                  misaligned;

    assign req = i_mem_read | i_mem_write;

    // Legality of the presented access: alignment per size, and reserved funct3 codes
    always_comb begin
        bad_req = 1'b0;
        case (i_funct3)
            3'b000, 3'b100: bad_req = 1'b0;
            3'b001, 3'b101: bad_req = i_addr[0];
            3'b010:         bad_req = (i_addr[1:0] != 2'b00);
            default:        bad_req = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated store data; loads use the same enables
    always_comb begin
        be_fmt    = 4'b1111;
        wdata_fmt = i_wdata;
        case (i_funct3[1:0])
            2'b00: begin
                be_fmt    = 4'b0001 << i_addr[1:0];
                wdata_fmt = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                be_fmt    = i_addr[1] ? 4'b1100 : 4'b0011;
                wdata_fmt = {2{i_wdata[15:0]}};
            end
            default: begin
                be_fmt    = 4'b1111;
                wdata_fmt = i_wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of the returned word
    always_comb begin
        case (lane_q)
            2'd0:    byte_sel = i_bus_rdata[7:0];
            2'd1:    byte_sel = i_bus_rdata[15:8];
            2'd2:    byte_sel = i_bus_rdata[23:16];
            default: byte_sel = i_bus_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
        case (funct3_q)
            3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  load_ext = {24'd0, byte_sel};
            3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
            3'b101:  load_ext = {16'd0, half_sel};
            default: load_ext = i_bus_rdata;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        funct3_d    = funct3_q;
        lane_d      = lane_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        rdata_d     = '0;
        stall       = 1'b0;
        misaligned  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (bad_req) begin
                        misaligned = 1'b1;
                    end else begin
                        stall       = 1'b1;
                        state_d     = REQ;
                        bus_valid_d = 1'b1;
                        bus_we_d    = i_mem_write;
                        bus_addr_d  = {i_addr[ADDR_WIDTH-1:2], 2'b00};
                        bus_be_d    = be_fmt;
                        bus_wdata_d = i_mem_write ? wdata_fmt : '0;
                        funct3_d    = i_funct3;
                        lane_d      = i_addr[1:0];
                    end
                end
            end
            REQ: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (i_bus_ready) begin
                    bus_valid_d = 1'b0;
                    state_d     = RESP;
                end else if (cnt_q >= CNT_LAST) begin
                    // abort: request withdrawn without a handshake
                    bus_valid_d = 1'b0;
                    state_d     = DONE;
                    done_d      = 1'b1;
                    err_d       = 1'b1;
                end
            end
            RESP: begin
                stall = 1'b1;
                cnt_d = cnt_q + 8'd1;
                if (i_bus_rvalid) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = i_bus_err;
                    rdata_d = (i_bus_err || bus_we_q) ? '0 : load_ext;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Combinational handshakes are forced low while reset is held
    assign o_stall      = stall & ~rst;
    assign o_misaligned = misaligned & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            funct3_q    <= '0;
            lane_q      <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            funct3_q    <= funct3_d;
            lane_q      <= lane_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
        end
    end

    assign o_done      = done_q;
    assign o_bus_err   = err_q;
    assign o_rdata     = rdata_q;
    assign o_bus_valid = bus_valid_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_be    = bus_be_q;
    assign o_bus_wdata = bus_wdata_q;

endmodule
